// File: rtl/lane_collector.sv
// lane_collector: gathers the 64 finished 25-bit state slices streamed out by the
// encoder, transposes them slice-major -> lane-major in a 25x64 buffer, and emits the
// 25 lanes over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous abort back to IDLE, buffered data discarded
//   sliceIn    slice data, slices delivered in order 0..NUM_SLICES-1
//   sliceValid sliceIn carries a valid slice
//   sliceReady block can accept a slice (low only while draining)
//   laneOut    current lane (zero when no lane is valid)
//   laneIdx    index of the lane on laneOut
//   laneValid  laneOut/laneIdx are valid
//   laneReady  consumer accepts the lane
//   done       one-cycle pulse after the last lane is accepted
module lane_collector #(
    parameter int unsigned SLICE_W    = 25,
    parameter int unsigned NUM_SLICES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [SLICE_W-1:0]    sliceIn,
    input  logic                  sliceValid,
    output logic                  sliceReady,
    output logic [NUM_SLICES-1:0] laneOut,
    output logic [4:0]            laneIdx,
    output logic                  laneValid,
    input  logic                  laneReady,
    output logic                  done
);

    localparam int unsigned CntW = $clog2(NUM_SLICES);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDrain   = 2'd2
    } state_e;

    state_e                state;
    logic [CntW-1:0]       cnt;
    logic [NUM_SLICES-1:0] buffer [SLICE_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            cnt     <= '0;
            laneIdx <= '0;
            done    <= 1'b0;
            for (int i = 0; i < SLICE_W; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (clr) begin
                // Buffer is left as is: every column is rewritten before the next drain.
                state   <= StIdle;
                cnt     <= '0;
                laneIdx <= '0;
            end else begin
                case (state)
                    StIdle, StCollect: begin
                        // cnt is 0 in IDLE, so the first slice lands in column 0.
                        if (sliceValid) begin
                            for (int i = 0; i < SLICE_W; i++) begin
                                buffer[i][cnt] <= sliceIn[i];
                            end
                            if (cnt == CntW'(NUM_SLICES - 1)) begin
                                cnt   <= '0;
                                state <= StDrain;
                            end else begin
                                cnt   <= cnt + 1'b1;
                                state <= StCollect;
                            end
                        end
                    end
                    StDrain: begin
                        if (laneReady) begin
                            if (laneIdx == 5'(SLICE_W - 1)) begin
                                laneIdx <= '0;
                                done    <= 1'b1;
                                state   <= StIdle;
                            end else begin
                                laneIdx <= laneIdx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= StIdle;
                        cnt     <= '0;
                        laneIdx <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        sliceReady = (state != StDrain);
        laneValid  = (state == StDrain);
        laneOut    = laneValid ? buffer[laneIdx] : '0;
    end

endmodule
